i2s_dac_serializer: RTL and testbench

- Serializes stereo samples into the audio CODEC's DAC serial input, running from `CLOCK_50`.
- Accepts parallel left/right sample pairs through a ready/valid write handshake, the same one the codec interface presents to the filter datapath.
- Buffers the pairs in a small FIFO and shifts them out MSB-first on `AUD_DACDAT`, slaved to the codec-mastered `AUD_BCLK` and `AUD_DACLRCK`.
- Format is left-justified: `AUD_DACLRCK` high is the left channel.

---
 rtl/i2s_dac_serializer_if.sv | 23 ++
 rtl/i2s_dac_serializer.sv | 134 +++++++++++++
 tb/tb_i2s_dac_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_dac_serializer_if.sv
// Write-side handshake carrying stereo sample pairs into the DAC serializer.
interface i2s_dac_serializer_if #(
  parameter int DW = 24
);
  logic          write;
  logic [DW-1:0] writedata_left;
  logic [DW-1:0] writedata_right;
  logic          write_ready;

  modport master (
    output write,
    output writedata_left,
    output writedata_right,
    input  write_ready
  );

  modport slave (
    input  write,
    input  writedata_left,
    input  writedata_right,
    output write_ready
  );
endinterface

// File: rtl/i2s_dac_serializer.sv
// Left-justified I2S DAC serializer: buffers stereo pairs in a small FIFO and
// shifts them MSB-first onto AUD_DACDAT, slaved to codec BCLK/DACLRCK.
module i2s_dac_serializer #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  i2s_dac_serializer_if.slave    wr,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_DACLRCK,
  output logic                   AUD_DACDAT,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DW + 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] BITS_MAX = CW'(DW);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  logic [2:0]      bclk_sync;
  logic [2:0]      lr_sync;
  logic            bclk_fall;
  logic            lr_rise;
  logic            lr_fall;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [2*DW-1:0] head;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  logic [1:0]      state;
  logic [DW-1:0]   sr;
  logic [DW-1:0]   right_hold;
  logic [CW-1:0]   bit_cnt;

  // Three-flop synchronizers for the codec-mastered clocks (bit 0 = s1).
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lr_sync   <= {lr_sync[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall = ~bclk_sync[1] &  bclk_sync[2];
  assign lr_rise   =  lr_sync[1]   & ~lr_sync[2];
  assign lr_fall   = ~lr_sync[1]   &  lr_sync[2];

  assign wr.write_ready = (fifo_level != FULL_LVL);
  assign fifo_empty     = (fifo_level == '0);
  assign push           = wr.write && wr.write_ready;
  assign pop            = lr_rise && !fifo_empty;
  assign head           = mem[rp];

  // FIFO storage and pointers; readiness uses the pre-pop level so a full
  // FIFO refuses a push even in the cycle a frame pops an entry.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {wr.writedata_left, wr.writedata_right};
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame state machine and output shifter; LR edges take priority over a
  // coincident BCLK fall so a new word is loaded rather than shifted.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      right_hold <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (lr_rise) begin
        state   <= LEFT;
        bit_cnt <= CW'(1);
        if (!fifo_empty) begin
          sr         <= head[2*DW-1:DW];
          right_hold <= head[DW-1:0];
          AUD_DACDAT <= head[2*DW-1];
        end else begin
          sr         <= '0;
          right_hold <= '0;
          AUD_DACDAT <= 1'b0;
          underrun   <= 1'b1;
        end
      end else if (lr_fall && state == LEFT) begin
        state      <= RIGHT;
        sr         <= right_hold;
        AUD_DACDAT <= right_hold[DW-1];
        bit_cnt    <= CW'(1);
      end else if (bclk_fall && state != IDLE) begin
        sr <= sr << 1;
        if (bit_cnt < BITS_MAX) begin
          AUD_DACDAT <= sr[DW-2];
          bit_cnt    <= bit_cnt + 1'b1;
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Scoreboard bench for i2s_dac_serializer: a codec model drives BCLK/DACLRCK
// and captures AUD_DACDAT on BCLK rising edges.
module tb_i2s_dac_serializer;

  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk;
  logic       lrck;
  logic       dacdat;
  logic       underrun;
  logic [2:0] level;

  i2s_dac_serializer_if #(.DW(DW)) wr_if ();

  i2s_dac_serializer #(.DW(DW), .DEPTH(DEPTH)) u_dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .wr          (wr_if),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (lrck),
    .AUD_DACDAT  (dacdat),
    .underrun    (underrun),
    .fifo_level  (level)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*DW-1:0] sb_q [$];
  int exp_level = 0;
  int exp_urun  = 0;
  int urun_cnt  = 0;
  int urun_hi   = 0;
  logic urun_d  = 1'b0;

  // Count underrun pulses and the cycles they are high.
  always @(negedge clk) begin
    if (underrun) urun_hi++;
    if (underrun && !urun_d) urun_cnt++;
    urun_d = underrun;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_if.write = 1'b0;
    lrck = 1'b0;
    bclk = 1'b1;
    repeat (3) tick();
    chk("rst_dacdat", dacdat, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", wr_if.write_ready, 1);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    sb_q.delete();
    exp_level = 0;
    tick();
  endtask

  // Drive one pair for one cycle; the caller drops write when done.
  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit acc;
    wr_if.write = 1'b1;
    wr_if.writedata_left  = l;
    wr_if.writedata_right = r;
    acc = (exp_level != DEPTH);
    chk("push_ready", wr_if.write_ready, 64'(acc));
    tick();
    if (acc) begin
      sb_q.push_back({l, r});
      exp_level++;
    end
  endtask

  // One stereo frame of nb BCLK periods per channel.
  task automatic frame(input int nb, input bit lat);
    logic [2*DW-1:0] pair;
    logic [DW-1:0]   word;
    logic [63:0]     got;
    logic [63:0]     e;
    if (sb_q.size() == 0) begin
      pair = '0;
      exp_urun++;
    end else begin
      pair = sb_q.pop_front();
      exp_level--;
    end
    for (int ch = 0; ch < 2; ch++) begin
      word = (ch == 0) ? pair[2*DW-1:DW] : pair[DW-1:0];
      got = '0;
      e   = '0;
      for (int i = 0; i < nb; i++) begin
        bclk = 1'b0;
        if (i == 0) lrck = (ch == 0);
        if (lat && ch == 0 && i == 0) begin
          tick();
          chk("lat_k", dacdat, 0);
          tick();
          chk("lat_k1", dacdat, 0);
          tick();
          chk("lat_k2", dacdat, 64'(word[DW-1]));
          repeat (5) tick();
        end else begin
          repeat (8) tick();
        end
        got[63-i] = dacdat;
        if (i < DW) e[63-i] = word[DW-1-i];
        bclk = 1'b1;
        repeat (8) tick();
      end
      chk((ch == 0) ? "left_bits" : "right_bits", got, e);
    end
    chk("frame_level", level, 64'(exp_level));
    chk("urun_pulses", urun_cnt, 64'(exp_urun));
    chk("urun_cycles", urun_hi, 64'(exp_urun));
  endtask

  initial begin
    bit found;
    logic [63:0] idle_bits;
    rst = 1'b1;
    lrck = 1'b0;
    bclk = 1'b1;
    wr_if.write = 1'b0;
    wr_if.writedata_left  = '0;
    wr_if.writedata_right = '0;

    // Single pair, 32 BCLK per channel, with output latency check.
    do_reset();
    push(24'hA5A5A5, 24'h3C0F01);
    wr_if.write = 1'b0;
    chk("one_level", level, 1);
    frame(32, 1'b1);

    // Overfill: fifth pair is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) push(24'h100000 + 24'(i), 24'h800000 + 24'(i * 3));
    wr_if.write = 1'b0;
    chk("full_level", level, 4);
    chk("full_ready", wr_if.write_ready, 0);
    frame(32, 1'b0);
    chk("after_pop_ready", wr_if.write_ready, 1);
    for (int i = 0; i < 3; i++) frame(32, 1'b0);
    frame(32, 1'b0);

    // Starved frames.
    for (int i = 0; i < 3; i++) frame(32, 1'b0);

    // Write held at full while a frame pops.
    do_reset();
    for (int i = 0; i < 4; i++) push(24'h0F0000 + 24'(i), 24'h00F000 + 24'(i));
    wr_if.writedata_left  = 24'h123456;
    wr_if.writedata_right = 24'h654321;
    lrck = 1'b1;
    bclk = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!found && level != 3'd4) begin
        found = 1'b1;
        chk("popfull_level", level, 3);
        chk("popfull_ready", wr_if.write_ready, 1);
        tick();
        chk("popfull_push", level, 4);
      end
    end
    chk("popfull_seen", found, 1);
    wr_if.write = 1'b0;

    // Reset ten bits into a left word.
    do_reset();
    for (int i = 0; i < 4; i++) push(24'hFFFFFF, 24'h0000AA + 24'(i));
    wr_if.write = 1'b0;
    lrck = 1'b1;
    bclk = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      bclk = 1'b1;
      repeat (8) tick();
      bclk = 1'b0;
      repeat (8) tick();
    end
    chk("mid_level", level, 3);
    chk("mid_dacdat", dacdat, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_dacdat", dacdat, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", wr_if.write_ready, 1);
    lrck = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    sb_q.delete();
    exp_level = 0;
    idle_bits = '0;
    for (int i = 0; i < 16; i++) begin
      bclk = 1'b0;
      repeat (8) tick();
      idle_bits[63-i] = dacdat;
      bclk = 1'b1;
      repeat (8) tick();
    end
    chk("idle_quiet", idle_bits, 0);
    chk("idle_no_urun", urun_cnt, 64'(exp_urun));
    frame(32, 1'b0);

    // Short frames truncate each word to its upper 16 bits.
    push(24'hC3A501, 24'h5AF0FF);
    push(24'h813C7E, 24'hE7180F);
    wr_if.write = 1'b0;
    frame(16, 1'b0);
    frame(16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
